// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings: ALU opcodes, branch conditions,
// writeback selects and forwarding selects.
// Pure constants; no logic, no latency, no flow control.
package riscv_pkg;

  // ALU opcodes (aluControl)
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // Branch conditions (funct3)
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // Writeback select (resultSrc)
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Operand forwarding select (forwardAE / forwardBE)
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Integer ALU for the execute stage (add/sub/logic/compare/shift).
// Latency: purely combinational, result valid in the same cycle.
// Backpressure: none; no handshake, output follows inputs.
//
// Ports:
//   i_srcA, i_srcB  operands (XLEN)
//   i_aluControl    4-bit opcode (riscv_pkg ALU_*)
//   o_result        result (XLEN); unknown opcodes give 0
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_srcA,
  input  logic [XLEN-1:0] i_srcB,
  input  logic [3:0]      i_aluControl,
  output logic [XLEN-1:0] o_result
);

  logic [4:0] w_shamt;
  logic       w_lt;
  logic       w_ltu;

  assign w_shamt = i_srcB[4:0];
  assign w_lt    = $signed(i_srcA) < $signed(i_srcB);
  assign w_ltu   = i_srcA < i_srcB;

  always_comb begin
    o_result = '0;
    case (i_aluControl)
      ALU_ADD:  o_result = i_srcA + i_srcB;
      ALU_SUB:  o_result = i_srcA - i_srcB;
      ALU_AND:  o_result = i_srcA & i_srcB;
      ALU_OR:   o_result = i_srcA | i_srcB;
      ALU_XOR:  o_result = i_srcA ^ i_srcB;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, w_ltu};
      ALU_SLL:  o_result = i_srcA << w_shamt;
      ALU_SRL:  o_result = i_srcA >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_srcA) >>> w_shamt);
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch/jump resolve, EX/MEM register.
// Latency: D inputs reach M outputs after 2 rising edges; pcSrcE/pcTargetE are combinational off ID/EX.
// Backpressure: none; ID/EX loads every cycle (bubble when flushE), EX/MEM always loads.
//
// Ports:
//   clk, reset (async, active-high), flushE
//   D side : rd1D, rd2D, immExtD, pcD, pcPlus4D, rs1D, rs2D, rdD, decoded controls
//   EX side: forwardAE/forwardBE, resultW in; rs1E/rs2E/rdE, resultSrcE0, pcSrcE, pcTargetE out
//   M side : regWriteM, memWriteM, resultSrcM, rdM, aluResultM, writeDataM, pcPlus4M
module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flushE,
  input  logic [XLEN-1:0] rd1D,
  input  logic [XLEN-1:0] rd2D,
  input  logic [XLEN-1:0] immExtD,
  input  logic [XLEN-1:0] pcD,
  input  logic [XLEN-1:0] pcPlus4D,
  input  logic [REGW-1:0] rs1D,
  input  logic [REGW-1:0] rs2D,
  input  logic [REGW-1:0] rdD,
  input  logic            regWriteD,
  input  logic            memWriteD,
  input  logic            branchD,
  input  logic            jumpD,
  input  logic            jalrD,
  input  logic            aluSrcD,
  input  logic [1:0]      resultSrcD,
  input  logic [3:0]      aluControlD,
  input  logic [2:0]      funct3D,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] resultW,
  output logic [REGW-1:0] rs1E,
  output logic [REGW-1:0] rs2E,
  output logic [REGW-1:0] rdE,
  output logic            resultSrcE0,
  output logic            pcSrcE,
  output logic [XLEN-1:0] pcTargetE,
  output logic            regWriteM,
  output logic            memWriteM,
  output logic [1:0]      resultSrcM,
  output logic [REGW-1:0] rdM,
  output logic [XLEN-1:0] aluResultM,
  output logic [XLEN-1:0] writeDataM,
  output logic [XLEN-1:0] pcPlus4M
);

  // ---------------- ID/EX register ----------------
  logic [XLEN-1:0] r_rd1E, r_rd2E, r_immExtE, r_pcE, r_pcPlus4E;
  logic [REGW-1:0] r_rs1E, r_rs2E, r_rdE;
  logic            r_regWriteE, r_memWriteE, r_branchE, r_jumpE, r_jalrE, r_aluSrcE;
  logic [1:0]      r_resultSrcE;
  logic [3:0]      r_aluControlE;
  logic [2:0]      r_funct3E;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flushE) begin
      // A flush loads the same all-zero bubble as reset.
      r_rd1E        <= '0;
      r_rd2E        <= '0;
      r_immExtE     <= '0;
      r_pcE         <= '0;
      r_pcPlus4E    <= '0;
      r_rs1E        <= '0;
      r_rs2E        <= '0;
      r_rdE         <= '0;
      r_regWriteE   <= 1'b0;
      r_memWriteE   <= 1'b0;
      r_branchE     <= 1'b0;
      r_jumpE       <= 1'b0;
      r_jalrE       <= 1'b0;
      r_aluSrcE     <= 1'b0;
      r_resultSrcE  <= '0;
      r_aluControlE <= '0;
      r_funct3E     <= '0;
    end else begin
      r_rd1E        <= rd1D;
      r_rd2E        <= rd2D;
      r_immExtE     <= immExtD;
      r_pcE         <= pcD;
      r_pcPlus4E    <= pcPlus4D;
      r_rs1E        <= rs1D;
      r_rs2E        <= rs2D;
      r_rdE         <= rdD;
      r_regWriteE   <= regWriteD;
      r_memWriteE   <= memWriteD;
      r_branchE     <= branchD;
      r_jumpE       <= jumpD;
      r_jalrE       <= jalrD;
      r_aluSrcE     <= aluSrcD;
      r_resultSrcE  <= resultSrcD;
      r_aluControlE <= aluControlD;
      r_funct3E     <= funct3D;
    end
  end

  // ---------------- Operand forwarding ----------------
  logic [XLEN-1:0] w_srcAE, w_writeDataE, w_srcBE, w_aluResultE;

  always_comb begin
    w_srcAE = r_rd1E;
    case (forwardAE)
      FWD_WB:  w_srcAE = resultW;
      FWD_MEM: w_srcAE = aluResultM;
      default: w_srcAE = r_rd1E;
    endcase
  end

  always_comb begin
    w_writeDataE = r_rd2E;
    case (forwardBE)
      FWD_WB:  w_writeDataE = resultW;
      FWD_MEM: w_writeDataE = aluResultM;
      default: w_writeDataE = r_rd2E;
    endcase
  end

  assign w_srcBE = r_aluSrcE ? r_immExtE : w_writeDataE;

  alu #(.XLEN(XLEN)) u_alu (
    .i_srcA       (w_srcAE),
    .i_srcB       (w_srcBE),
    .i_aluControl (r_aluControlE),
    .o_result     (w_aluResultE)
  );

  // ---------------- Branch / jump resolve ----------------
  // Branches compare against the forwarded rs2 value, never the immediate.
  logic            w_eq, w_lt, w_ltu, w_taken;
  logic [XLEN-1:0] w_jalrSum;

  assign w_eq  = w_srcAE == w_writeDataE;
  assign w_lt  = $signed(w_srcAE) < $signed(w_writeDataE);
  assign w_ltu = w_srcAE < w_writeDataE;

  always_comb begin
    w_taken = 1'b0;
    case (r_funct3E)
      BR_EQ:   w_taken = w_eq;
      BR_NE:   w_taken = ~w_eq;
      BR_LT:   w_taken = w_lt;
      BR_GE:   w_taken = ~w_lt;
      BR_LTU:  w_taken = w_ltu;
      BR_GEU:  w_taken = ~w_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_jalrSum   = w_srcAE + r_immExtE;
  assign pcSrcE      = r_jumpE | (r_branchE & w_taken);
  assign pcTargetE   = r_jalrE ? {w_jalrSum[XLEN-1:1], 1'b0} : (r_pcE + r_immExtE);
  assign rs1E        = r_rs1E;
  assign rs2E        = r_rs2E;
  assign rdE         = r_rdE;
  assign resultSrcE0 = r_resultSrcE[0];

  // ---------------- EX/MEM register ----------------
  logic            r_regWriteM, r_memWriteM;
  logic [1:0]      r_resultSrcM;
  logic [REGW-1:0] r_rdM;
  logic [XLEN-1:0] r_aluResultM, r_writeDataM, r_pcPlus4M;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regWriteM  <= 1'b0;
      r_memWriteM  <= 1'b0;
      r_resultSrcM <= '0;
      r_rdM        <= '0;
      r_aluResultM <= '0;
      r_writeDataM <= '0;
      r_pcPlus4M   <= '0;
    end else begin
      r_regWriteM  <= r_regWriteE;
      r_memWriteM  <= r_memWriteE;
      r_resultSrcM <= r_resultSrcE;
      r_rdM        <= r_rdE;
      r_aluResultM <= w_aluResultE;
      r_writeDataM <= w_writeDataE;
      r_pcPlus4M   <= r_pcPlus4E;
    end
  end

  assign regWriteM  = r_regWriteM;
  assign memWriteM  = r_memWriteM;
  assign resultSrcM = r_resultSrcM;
  assign rdM        = r_rdM;
  assign aluResultM = r_aluResultM;
  assign writeDataM = r_writeDataM;
  assign pcPlus4M   = r_pcPlus4M;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table of instructions streamed back-to-back through the
// stage, EX outputs checked from the table, M outputs checked from a scoreboard queue.
module tb_ex_stage;
  import riscv_pkg::*;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int NV   = 28;

  logic            clk = 1'b0;
  logic            reset;
  logic            flushE;
  logic [XLEN-1:0] rd1D, rd2D, immExtD, pcD, pcPlus4D, resultW;
  logic [REGW-1:0] rs1D, rs2D, rdD;
  logic            regWriteD, memWriteD, branchD, jumpD, jalrD, aluSrcD;
  logic [1:0]      resultSrcD, forwardAE, forwardBE;
  logic [3:0]      aluControlD;
  logic [2:0]      funct3D;
  logic [REGW-1:0] rs1E, rs2E, rdE, rdM;
  logic            resultSrcE0, pcSrcE, regWriteM, memWriteM;
  logic [XLEN-1:0] pcTargetE, aluResultM, writeDataM, pcPlus4M;
  logic [1:0]      resultSrcM;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .reset(reset), .flushE(flushE),
    .rd1D(rd1D), .rd2D(rd2D), .immExtD(immExtD), .pcD(pcD), .pcPlus4D(pcPlus4D),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .regWriteD(regWriteD), .memWriteD(memWriteD), .branchD(branchD), .jumpD(jumpD),
    .jalrD(jalrD), .aluSrcD(aluSrcD), .resultSrcD(resultSrcD), .aluControlD(aluControlD),
    .funct3D(funct3D), .forwardAE(forwardAE), .forwardBE(forwardBE), .resultW(resultW),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .resultSrcE0(resultSrcE0),
    .pcSrcE(pcSrcE), .pcTargetE(pcTargetE),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM), .rdM(rdM),
    .aluResultM(aluResultM), .writeDataM(writeDataM), .pcPlus4M(pcPlus4M)
  );

  typedef struct {
    logic [31:0] rd1, rd2, imm, pc, pcp4, resw;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, br, j, jr, asrc, flush;
    logic [1:0]  rsrc, fa, fb;
    logic [3:0]  aluc;
    logic [2:0]  f3;
    logic        exp_pcsrc;
    logic [31:0] exp_tgt, exp_alu, exp_wd;
  } vec_t;

  typedef struct {
    int          idx;
    logic        rw, mw;
    logic [1:0]  rsrc;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pcp4;
  } mexp_t;

  vec_t  vt [NV];
  mexp_t sb [$];
  int    pass_cnt = 0;
  int    tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] aluc, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [31:0] resw, input logic [31:0] ealu, input logic [31:0] ewd);
    vec_t v;
    v = '{default: '0};
    v.aluc = aluc; v.rd1 = a; v.rd2 = b; v.rd = rd;
    v.rs1 = rd + 5'd1; v.rs2 = rd + 5'd2; v.rw = 1'b1;
    v.fa = fa; v.fb = fb; v.resw = resw;
    v.pcp4 = 32'hA0 + {27'd0, rd};
    v.exp_alu = ealu; v.exp_wd = ewd;
    return v;
  endfunction

  function automatic vec_t mk_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic taken);
    vec_t v;
    v = mk(ALU_ADD, a, b, 5'd0, FWD_RF, FWD_RF, 32'd0, a + b, b);
    v.rw = 1'b0; v.br = 1'b1; v.f3 = f3;
    v.pc = 32'h100; v.imm = 32'h10; v.exp_tgt = 32'h110; v.exp_pcsrc = taken;
    return v;
  endfunction

  task automatic drive_d(input vec_t v);
    flushE = v.flush; rd1D = v.rd1; rd2D = v.rd2; immExtD = v.imm; pcD = v.pc;
    pcPlus4D = v.pcp4; rs1D = v.rs1; rs2D = v.rs2; rdD = v.rd;
    regWriteD = v.rw; memWriteD = v.mw; branchD = v.br; jumpD = v.j; jalrD = v.jr;
    aluSrcD = v.asrc; resultSrcD = v.rsrc; aluControlD = v.aluc; funct3D = v.f3;
  endtask

  task automatic zero_d();
    vec_t v;
    v = '{default: '0};
    drive_d(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  v;
    mexp_t m;

    // ---------------- vector table ----------------
    vt[0]  = mk(ALU_ADD,  32'd3,        32'd4,     5'd5,  FWD_RF,  FWD_RF, 0,        32'd7,        32'd4);
    vt[1]  = mk(ALU_ADD,  32'd0,        32'd1,     5'd6,  FWD_MEM, FWD_RF, 0,        32'd8,        32'd1);
    vt[2]  = mk(ALU_SUB,  32'h10,       32'h99,    5'd7,  FWD_RF,  FWD_WB, 32'h20,   32'hFFFFFFF0, 32'h20);
    vt[3]  = mk(ALU_AND,  32'hF0F0,     32'hFF00,  5'd8,  FWD_RF,  FWD_RF, 0,        32'hF000,     32'hFF00);
    vt[4]  = mk(ALU_OR,   32'hF0F0,     32'hFF00,  5'd9,  FWD_RF,  FWD_RF, 0,        32'hFFF0,     32'hFF00);
    vt[5]  = mk(ALU_XOR,  32'hF0F0,     32'hFF00,  5'd10, FWD_RF,  FWD_RF, 0,        32'h0FF0,     32'hFF00);
    vt[6]  = mk(ALU_SLT,  32'hFFFFFFFF, 32'd1,     5'd11, FWD_RF,  FWD_RF, 0,        32'd1,        32'd1);
    vt[7]  = mk(ALU_SLTU, 32'hFFFFFFFF, 32'd1,     5'd12, FWD_RF,  FWD_RF, 0,        32'd0,        32'd1);
    vt[8]  = mk(ALU_SLL,  32'd1,        32'h23,    5'd13, FWD_RF,  FWD_RF, 0,        32'd8,        32'h23);
    vt[9]  = mk(ALU_SRL,  32'h80000000, 32'd4,     5'd14, FWD_RF,  FWD_RF, 0,        32'h08000000, 32'd4);
    vt[10] = mk(ALU_SRA,  32'h80000000, 32'd4,     5'd15, FWD_RF,  FWD_RF, 0,        32'hF8000000, 32'd4);
    vt[11] = mk(4'hF,     32'd5,        32'd6,     5'd16, FWD_RF,  FWD_RF, 0,        32'd0,        32'd6);
    vt[12] = mk(ALU_ADD,  32'd10,       32'h55,    5'd17, FWD_RF,  FWD_RF, 0,        32'h2A,       32'h55);
    vt[12].asrc = 1'b1; vt[12].imm = 32'h20; vt[12].exp_tgt = 32'h20;
    vt[13] = mk(ALU_ADD,  32'd2,        32'd3,     5'd0,  2'b11,   2'b11,  32'h999,  32'd5,        32'd3);
    vt[14] = mk_br(BR_NE,  32'd5,        32'd5, 1'b0);
    vt[15] = mk_br(BR_LT,  32'hFFFFFFFF, 32'd1, 1'b1);
    vt[16] = mk_br(BR_LTU, 32'hFFFFFFFF, 32'd1, 1'b0);
    vt[17] = mk_br(BR_EQ,  32'd5,        32'd5, 1'b1);
    vt[17].asrc = 1'b1; vt[17].exp_alu = 32'h15;  // compare must use rs2, not imm
    vt[18] = mk_br(BR_GE,  32'hFFFFFFFF, 32'd1, 1'b0);
    vt[19] = mk_br(BR_GEU, 32'hFFFFFFFF, 32'd1, 1'b1);
    vt[20] = mk_br(3'b010, 32'd5,        32'd5, 1'b0);
    vt[21] = mk_br(3'b011, 32'd3,        32'd3, 1'b0);
    vt[22] = mk_br(BR_EQ,  32'd7,        32'd7, 1'b1);
    vt[22].pc = 32'h200; vt[22].imm = 32'h20; vt[22].exp_tgt = 32'h220;
    // Flush arrives while the taken branch above sits in EX.
    vt[23] = mk(ALU_ADD, 32'h77, 32'h88, 5'd3, FWD_RF, FWD_RF, 0, 32'd0, 32'd0);
    vt[23].mw = 1'b1; vt[23].rs1 = 5'd9; vt[23].flush = 1'b1;
    vt[24] = mk(ALU_ADD, 32'h1003, 32'd0, 5'd1, FWD_RF, FWD_RF, 0, 32'h1007, 32'd0);
    vt[24].asrc = 1'b1; vt[24].imm = 32'd4; vt[24].pcp4 = 32'h204; vt[24].rsrc = RES_PC4;
    vt[24].j = 1'b1; vt[24].jr = 1'b1; vt[24].exp_pcsrc = 1'b1; vt[24].exp_tgt = 32'h1006;
    vt[25] = mk(ALU_ADD, 32'd0, 32'd0, 5'd2, FWD_RF, FWD_RF, 0, 32'd0, 32'd0);
    vt[25].pc = 32'h300; vt[25].imm = 32'h40; vt[25].pcp4 = 32'h304; vt[25].rsrc = RES_PC4;
    vt[25].j = 1'b1; vt[25].exp_pcsrc = 1'b1; vt[25].exp_tgt = 32'h340;
    vt[26] = mk(ALU_ADD, 32'h100, 32'd0, 5'd20, FWD_RF, FWD_RF, 0, 32'h108, 32'd0);
    vt[26].asrc = 1'b1; vt[26].imm = 32'd8; vt[26].rsrc = RES_MEM; vt[26].exp_tgt = 32'd8;
    vt[27] = mk(ALU_ADD, 32'h200, 32'hDEAD, 5'd0, FWD_RF, FWD_RF, 0, 32'h204, 32'hDEAD);
    vt[27].asrc = 1'b1; vt[27].imm = 32'd4; vt[27].rw = 1'b0; vt[27].mw = 1'b1; vt[27].exp_tgt = 32'd4;

    // ---------------- reset and mid-stream async reset ----------------
    reset = 1'b1; forwardAE = FWD_RF; forwardBE = FWD_RF; resultW = '0;
    zero_d();
    #12;
    chk("rst regWriteM",  {31'd0, regWriteM},  0);
    chk("rst aluResultM", aluResultM,          0);
    chk("rst rdM",        {27'd0, rdM},        0);
    chk("rst pcSrcE",     {31'd0, pcSrcE},     0);
    reset = 1'b0;
    drive_d(vt[0]);
    @(posedge clk); #1;
    v = '{default: '0}; v.j = 1'b1; v.pc = 32'h40; v.imm = 32'd4;
    drive_d(v);
    @(posedge clk); #1;
    chk("pre-rst aluResultM", aluResultM,         32'd7);
    chk("pre-rst regWriteM",  {31'd0, regWriteM}, 1);
    chk("pre-rst pcSrcE",     {31'd0, pcSrcE},    1);
    #2 reset = 1'b1;
    #1;
    chk("async rst regWriteM",  {31'd0, regWriteM}, 0);
    chk("async rst aluResultM", aluResultM,         0);
    chk("async rst rdM",        {27'd0, rdM},       0);
    chk("async rst pcSrcE",     {31'd0, pcSrcE},    0);
    zero_d();
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // ---------------- streamed table ----------------
    for (int c = 0; c < NV + 2; c++) begin
      if (c >= 2) begin
        if (sb.size() == 0) begin
          chk("scoreboard underflow", 32'd0, 32'd1);
        end else begin
          m = sb.pop_front();
          chk($sformatf("v%0d regWriteM",  m.idx), {31'd0, regWriteM},  {31'd0, m.rw});
          chk($sformatf("v%0d memWriteM",  m.idx), {31'd0, memWriteM},  {31'd0, m.mw});
          chk($sformatf("v%0d resultSrcM", m.idx), {30'd0, resultSrcM}, {30'd0, m.rsrc});
          chk($sformatf("v%0d rdM",        m.idx), {27'd0, rdM},        {27'd0, m.rd});
          chk($sformatf("v%0d aluResultM", m.idx), aluResultM,          m.alu);
          chk($sformatf("v%0d writeDataM", m.idx), writeDataM,          m.wd);
          chk($sformatf("v%0d pcPlus4M",   m.idx), pcPlus4M,            m.pcp4);
        end
      end
      if (c >= 1 && c <= NV) begin
        v = vt[c-1];
        forwardAE = v.fa; forwardBE = v.fb; resultW = v.resw;
        #1;
        chk($sformatf("v%0d rs1E", c-1),        {27'd0, rs1E},        v.flush ? 0 : {27'd0, v.rs1});
        chk($sformatf("v%0d rs2E", c-1),        {27'd0, rs2E},        v.flush ? 0 : {27'd0, v.rs2});
        chk($sformatf("v%0d rdE", c-1),         {27'd0, rdE},         v.flush ? 0 : {27'd0, v.rd});
        chk($sformatf("v%0d resultSrcE0", c-1), {31'd0, resultSrcE0}, v.flush ? 0 : {31'd0, v.rsrc[0]});
        chk($sformatf("v%0d pcSrcE", c-1),      {31'd0, pcSrcE},      v.flush ? 0 : {31'd0, v.exp_pcsrc});
        chk($sformatf("v%0d pcTargetE", c-1),   pcTargetE,            v.flush ? 0 : v.exp_tgt);
      end else begin
        forwardAE = FWD_RF; forwardBE = FWD_RF; resultW = '0;
      end
      if (c < NV) begin
        v = vt[c];
        drive_d(v);
        m.idx = c;
        if (v.flush) begin
          m.rw = 1'b0; m.mw = 1'b0; m.rsrc = '0; m.rd = '0; m.alu = '0; m.wd = '0; m.pcp4 = '0;
        end else begin
          m.rw = v.rw; m.mw = v.mw; m.rsrc = v.rsrc; m.rd = v.rd;
          m.alu = v.exp_alu; m.wd = v.exp_wd; m.pcp4 = v.pcp4;
        end
        sb.push_back(m);
      end else begin
        zero_d();
      end
      @(posedge clk); #1;
    end
    chk("scoreboard drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
